// File: rtl/minv_pkg.sv
// Shared types for the modular inversion/division engine: FSM states, mode
// encodings and the operand load phases.
package minv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        OUT  = 3'd4,
        FIN  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PH_P = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } phase_e;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_INV = 1'b1;

endpackage

// File: rtl/minv_half_mod.sv
// Modular halving: x/2 mod p for odd p, using one extra bit so x+p cannot overflow.
module minv_half_mod #(
    parameter int OP_W = 256
) (
    input  logic [OP_W-1:0] x_i,
    input  logic [OP_W-1:0] p_i,
    output logic [OP_W-1:0] y_o
);
    logic [OP_W:0] sum;
    logic          sum_lsb_unused;

    assign sum            = {1'b0, x_i} + (x_i[0] ? {1'b0, p_i} : '0);
    assign y_o            = sum[OP_W:1];
    assign sum_lsb_unused = sum[0];

endmodule

// File: rtl/minv_mdiv_engine.sv
// Word-serial binary extended Euclid engine: a^-1 mod p or b*a^-1 mod p.
// Optional macro MINV_ITER_LIMIT_EN bounds RUN and adds the iter_cnt port.
module minv_mdiv_engine
    import minv_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int OP_W   = 256,
    parameter int NW     = OP_W / WORD_W,
    localparam int WCW   = (NW > 1) ? $clog2(NW) : 1,
    localparam int IW    = $clog2(2 * OP_W + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              din_valid,
    input  logic [WORD_W-1:0] din,
    output logic              busy,
    output logic              dout_valid,
    output logic [WORD_W-1:0] dout,
    output logic              done,
    output logic              err
`ifdef MINV_ITER_LIMIT_EN
    ,
    output logic [IW-1:0]     iter_cnt
`endif
);
    localparam logic [WCW-1:0] W_LAST = WCW'(NW - 1);

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            mode_q, mode_d;
    logic            first_q, first_d;
    logic            err_q, err_d;
    logic [OP_W-1:0] p_q, p_d, u_q, u_d, v_q, v_d;
    logic [OP_W-1:0] x1_q, x1_d, x2_q, x2_d, res_q, res_d;
    logic [OP_W-1:0] x1_half, x2_half, x1_sub, x2_sub;
    logic [OP_W:0]   d12, d21;

`ifdef MINV_ITER_LIMIT_EN
    localparam logic [IW-1:0] ITER_MAX = IW'(2 * OP_W + 1);
    logic [IW-1:0] iter_q, iter_d;
    assign iter_cnt = iter_q;
`endif

    // Words arrive LSW first, so each new word enters at the top and shifts down.
    function automatic logic [OP_W-1:0] shin(input logic [OP_W-1:0] r, input logic [WORD_W-1:0] w);
        logic [OP_W+WORD_W-1:0] t;
        t = {w, r};
        return t[OP_W+WORD_W-1:WORD_W];
    endfunction

    minv_half_mod #(.OP_W(OP_W)) u_half_x1 (.x_i(x1_q), .p_i(p_q), .y_o(x1_half));
    minv_half_mod #(.OP_W(OP_W)) u_half_x2 (.x_i(x2_q), .p_i(p_q), .y_o(x2_half));

    // Both operands are in [0,p), so one conditional +p restores the range.
    assign d12    = {1'b0, x1_q} - {1'b0, x2_q};
    assign d21    = {1'b0, x2_q} - {1'b0, x1_q};
    assign x1_sub = d12[OP_W] ? d12[OP_W-1:0] + p_q : d12[OP_W-1:0];
    assign x2_sub = d21[OP_W] ? d21[OP_W-1:0] + p_q : d21[OP_W-1:0];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wcnt_d  = wcnt_q;
        mode_d  = mode_q;
        first_d = first_q;
        err_d   = err_q;
        p_d     = p_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        res_d   = res_q;
`ifdef MINV_ITER_LIMIT_EN
        iter_d  = iter_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    mode_d  = mode;
                    phase_d = PH_P;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    p_d     = '0;
                    u_d     = '0;
                    v_d     = '0;
                    x1_d    = '0;
                    x2_d    = '0;
                    res_d   = '0;
`ifdef MINV_ITER_LIMIT_EN
                    iter_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (din_valid) begin
                    case (phase_q)
                        PH_P: begin
                            p_d = shin(p_q, din);
                            v_d = shin(v_q, din);
                        end
                        PH_A:    u_d  = shin(u_q, din);
                        default: x1_d = shin(x1_q, din);
                    endcase
                    if (wcnt_q == W_LAST) begin
                        wcnt_d = '0;
                        if (phase_q == PH_P) begin
                            phase_d = PH_A;
                        end else if (phase_q == PH_A && mode_q == MODE_DIV) begin
                            phase_d = PH_B;
                        end else begin
                            state_d = RUN;
                            first_d = 1'b1;
`ifdef MINV_ITER_LIMIT_EN
                            iter_d  = '0;
`endif
                            if (mode_q == MODE_INV) x1_d = OP_W'(1);
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                first_d = 1'b0;
`ifdef MINV_ITER_LIMIT_EN
                iter_d  = iter_q + 1'b1;
`endif
                if (first_q && !p_q[0]) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
`ifdef MINV_ITER_LIMIT_EN
                else if (iter_q == ITER_MAX) begin
                    iter_d  = iter_q;
                    err_d   = 1'b1;
                    state_d = FIN;
                end
`endif
                else if (u_q == OP_W'(1) || v_q == OP_W'(1)) begin
                    state_d = FIX;
                end else if (u_q == '0 || v_q == '0) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end
            FIX: begin
                res_d   = (u_q == OP_W'(1)) ? x1_q : x2_q;
                wcnt_d  = '0;
                state_d = OUT;
            end
            OUT: begin
                res_d = res_q >> WORD_W;
                if (wcnt_q == W_LAST) begin
                    wcnt_d  = '0;
                    state_d = FIN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= PH_P;
            wcnt_q  <= '0;
            mode_q  <= MODE_DIV;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            p_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            res_q   <= '0;
`ifdef MINV_ITER_LIMIT_EN
            iter_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wcnt_q  <= wcnt_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            err_q   <= err_d;
            p_q     <= p_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            res_q   <= res_d;
`ifdef MINV_ITER_LIMIT_EN
            iter_q  <= iter_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign dout_valid = (state_q == OUT);
    assign dout       = (state_q == OUT) ? res_q[WORD_W-1:0] : '0;
    assign done       = (state_q == FIN);
    assign err        = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_minv_mdiv_engine.sv
// Directed + random bench for minv_mdiv_engine against a plain extended-Euclid model.
module tb_minv_mdiv_engine;
    localparam int WORD_W = 32;
    localparam int OP_W   = 256;
    localparam int NW     = OP_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst, start, mode, din_valid;
    logic [WORD_W-1:0] din;
    logic              busy, dout_valid, done, err;
    logic [WORD_W-1:0] dout;
`ifdef MINV_ITER_LIMIT_EN
    logic [9:0]        iter_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    minv_mdiv_engine #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .din_valid(din_valid), .din(din),
        .busy(busy), .dout_valid(dout_valid), .dout(dout),
        .done(done), .err(err)
`ifdef MINV_ITER_LIMIT_EN
        , .iter_cnt(iter_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Textbook extended Euclid; -1 when gcd(a,m) != 1.
    function automatic longint model_inv(input longint a, input longint m);
        longint t, nt, r, nr, q, tmp;
        t = 0; nt = 1; r = m; nr = a;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (r != 1) return -1;
        if (t < 0) t += m;
        return t;
    endfunction

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        logic [511:0] pr;
        pr = {256'b0, x} * {256'b0, y};
        pr = pr % {256'b0, m};
        return pr[255:0];
    endfunction

    task automatic run_op(input bit md, input logic [255:0] p, input logic [255:0] a,
                          input logic [255:0] b, input bit gaps, input int abort_at,
                          output logic [255:0] res, output logic e, output int ndone,
                          output int nval, output int first_val, output int done_cyc);
        logic [255:0] op;
        res = '0; e = 1'bx; ndone = 0; nval = 0; first_val = -1; done_cyc = -1;
        mode = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~md;
        for (int ph = 0; ph < (md ? 2 : 3); ph++) begin
            op = (ph == 0) ? p : (ph == 1) ? a : b;
            for (int w = 0; w < NW; w++) begin
                if (gaps) begin
                    din_valid = 1'b0; din = 32'hdead_beef;
                    @(posedge clk); #1;
                end
                din = op[w*32 +: 32]; din_valid = 1'b1;
                @(posedge clk); #1;
            end
        end
        din_valid = 1'b0; din = '0;
        for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
            if (c == abort_at) begin
                rst = 1'b0; #1;
                return;
            end
            if (dout_valid) begin
                if (first_val < 0) first_val = c;
                if (nval < NW) res[nval*32 +: 32] = dout;
                nval++;
            end
            if (done) begin
                ndone++; e = err; done_cyc = c;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [255:0] res, pbig, abig, bbig;
    logic         e;
    int           nd, nv, fv, dc;
    longint       rp, ra, rb, inv, expv;
    bit           rmd;

    initial begin
        rst = 1'b0; start = 1'b0; mode = 1'b0; din_valid = 1'b0; din = '0;
        #12;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_dout", {dout_valid, done, err, dout}, '0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 256'(busy), 256'd0);

        // case 1: inversion 3^-1 mod 17
        run_op(1'b1, 256'd17, 256'd3, 256'd0, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c1_res", res, 256'd6);
        chk("c1_err", 256'(e), 256'd0);
        chk("c1_ndone", 256'(nd), 256'd1);
        chk("c1_nval", 256'(nv), 256'(NW));
        chk("c1_done_after_out", 256'(dc == fv + NW), 256'd1);
        chk("c1_idle_after", {busy, done}, '0);

        // case 2: division 5/3 mod 17
        run_op(1'b0, 256'd17, 256'd3, 256'd5, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c2_res", res, 256'd13);
        chk("c2_err", 256'(e), 256'd0);

        // case 3: gcd(5,15)=5, no inverse
        run_op(1'b1, 256'd15, 256'd5, 256'd0, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c3_err", 256'(e), 256'd1);
        chk("c3_ndone", 256'(nd), 256'd1);
        chk("c3_nval", 256'(nv), 256'd0);

        // case 4: even modulus caught on first RUN cycle
        run_op(1'b1, 256'd16, 256'd3, 256'd0, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c4_err", 256'(e), 256'd1);
        chk("c4_done_cyc", 256'(dc), 256'd1);
        chk("c4_nval", 256'(nv), 256'd0);

        // case 5: a=1 goes straight to FIX, with and without din gaps
        run_op(1'b1, 256'd17, 256'd1, 256'd0, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c5_res", res, 256'd1);
        chk("c5_first_out", 256'(fv), 256'd2);
        run_op(1'b1, 256'd17, 256'd1, 256'd0, 1'b1, -1, res, e, nd, nv, fv, dc);
        chk("c5g_res", res, 256'd1);
        chk("c5g_err", 256'(e), 256'd0);

        // case 6: reset mid-RUN, then division again
        run_op(1'b1, 256'd17, 256'd3, 256'd0, 1'b0, 2, res, e, nd, nv, fv, dc);
        chk("c6_abort_outs", {busy, done, err, dout_valid}, '0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("c6_idle", {busy, done}, '0);
        run_op(1'b0, 256'd17, 256'd3, 256'd5, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("c6_res", res, 256'd13);
        chk("c6_ndone", 256'(nd), 256'd1);

        // random small operands against extended Euclid
        for (int i = 0; i < 12; i++) begin
            rp  = longint'($urandom_range(3, 65535) | 1);
            ra  = longint'($urandom_range(1, 32'(rp - 1)));
            rb  = longint'($urandom_range(0, 32'(rp - 1)));
            rmd = 1'($urandom_range(0, 1));
            inv = model_inv(ra, rp);
            expv = (inv < 0) ? 0 : (rmd ? inv : (rb * inv) % rp);
            run_op(rmd, 256'(rp), 256'(ra), 256'(rb), 1'(i & 1), -1, res, e, nd, nv, fv, dc);
            chk("rnd_ndone", 256'(nd), 256'd1);
            chk("rnd_err", 256'(e), 256'(inv < 0));
            chk("rnd_nval", 256'(nv), (inv < 0) ? 256'd0 : 256'(NW));
            if (inv >= 0) chk("rnd_res", res, 256'(expv));
        end

        // full-width operands: check the defining congruence
        pbig = {256{1'b1}} - 256'd188;
        for (int i = 0; i < 3; i++) begin
            abig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % pbig;
            if (abig == '0) abig = 256'd7;
            bbig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} % pbig;
            rmd = (i != 2);
            run_op(rmd, pbig, abig, bbig, 1'b0, -1, res, e, nd, nv, fv, dc);
            chk("big_err", 256'(e), 256'd0);
            chk("big_range", 256'(res < pbig), 256'd1);
            chk("big_cong", mulmod(res, abig, pbig), rmd ? 256'd1 : bbig);
        end

`ifdef MINV_ITER_LIMIT_EN
        abig = 256'd1 << 255;
        run_op(1'b1, pbig, abig, 256'd0, 1'b0, -1, res, e, nd, nv, fv, dc);
        chk("lim_err", 256'(e), 256'd0);
        chk("lim_iter", 256'(iter_cnt <= 10'd513), 256'd1);
        chk("lim_cong", mulmod(res, abig, pbig), 256'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/minv_mdiv_engine.md
Name: minv_mdiv_engine

Overview:
- Parametrised word-serial engine for modular inversion and division over an odd modulus p, using the binary extended Euclidean algorithm.
- Successor to the fixed 256/32 inversion datapath. Adds generic operand and word widths, an internal control FSM, a division/inversion mode select, and non-invertible-input detection.
- Operands are loaded and the result is unloaded one WORD_W word per cycle. Arithmetic runs at full OP_W width, one algorithm step per cycle.
- Sits beside the modular multiplier in the public-key arithmetic unit.

Parameters:
- WORD_W, 32: width of the data bus in and out.
- OP_W, 256: operand width. Must be a multiple of WORD_W.
- NW, OP_W/WORD_W: words per operand. Derived; not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse in IDLE; begins a load sequence.
- mode  input  1  sampled at start. 1 = inversion (a^-1 mod p), 0 = division (b*a^-1 mod p).
- din_valid  input  1  qualifies din during LOAD.
- din  input  WORD_W  operand word, least significant word first.
- busy  output  1  high in every state except IDLE.
- dout_valid  output  1  qualifies dout.
- dout  output  WORD_W  result word, least significant word first.
- done  output  1  one-cycle pulse when the operation ends.
- err  output  1  valid with done. 1 = no inverse, or p is even.

Behaviour:
- Reset: all state registers clear; FSM goes to IDLE. busy, dout_valid, done and err = 0; dout = 0.
- FSM states: IDLE, LOAD, RUN, FIX, OUT, FIN.
- IDLE: start latches mode and enters LOAD. start is ignored in every other state.
- LOAD: accepts words only on cycles with din_valid=1; gaps are allowed.
  - Order: NW words of p, then NW words of a, then NW words of b (mode=0 only).
  - A word counter steps 0..NW-1 per operand.
  - Initialise: u=a, v=p, x1=b (mode=0) or 1 (mode=1), x2=0.
  - After the last word, go to RUN.
- RUN precheck, first cycle: if p[0]=0, go to FIN with err=1.
- RUN step, one per cycle, first matching rule wins:
  1. u==1 or v==1: go to FIX.
  2. u==0 or v==0: go to FIN with err=1.
  3. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1, computed at OP_W+1 bits.
  4. v even: v=v>>1; x2 is updated the same way as x1 in rule 3.
  5. u>=v: u=u-v; x1 = x1-x2, plus p if the subtraction borrows.
  6. otherwise: v=v-u; x2 = x2-x1, plus p if the subtraction borrows.
- Invariant: x1 and x2 always stay in [0,p).
- Preconditions: 0<a<p and b<p. Behaviour outside these is undefined, except a=0, which reports err via rule 2.
- Latency bound: for valid inputs, RUN terminates within 2*OP_W steps.
- FIX: result register = x1 if u==1, else x2. Then go to OUT.
- OUT: NW consecutive cycles with dout_valid=1. No backpressure. Then go to FIN.
- FIN: done=1 for one cycle with err driven; return to IDLE.
- On an error path OUT is skipped, dout_valid stays 0, and dout holds 0.
- Asynchronous reset mid-operation: aborts immediately with no done pulse. Partial loads are discarded.
- din_valid outside LOAD is ignored.

Optional Feature:
- Macro: MINV_ITER_LIMIT_EN.
- Defined: a step counter of clog2(2*OP_W+2) bits clears on entry to RUN and increments every RUN cycle. When it reaches 2*OP_W+1, the engine goes to FIN with err=1. This guards against out-of-range inputs. An extra output, iter_cnt, exposes the final count; it holds until the next start.
- Not defined: no counter and no iter_cnt port. RUN is unbounded.

Decomposition:
- Package minv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, FIX, OUT, FIN);
  - mode encodings MODE_DIV=0 and MODE_INV=1;
  - the load-phase enum (PH_P, PH_A, PH_B).
- Sub-module minv_half_mod: combinational (x even ? x>>1 : (x+p)>>1) at OP_W+1 bits. Instantiated twice, for x1 and x2.
- Mod-subtract stays inline.

Test Plan:
All cases use OP_W=256 and WORD_W=32.
1. mode=1, p=17, a=3 -> dout words = 6,0,...,0; err=0; done one cycle after the last dout_valid.
2. mode=0, p=17, a=3, b=5 -> result 13; err=0.
3. mode=1, p=15, a=5 -> done with err=1; dout_valid never asserted.
4. mode=1, p=16, a=3 -> err=1 on the first RUN cycle; done follows.
5. mode=1, p=17, a=1 -> result 1, reached via FIX on the first RUN cycle. Also: load with din_valid gaps every other cycle -> same result.
6. Assert rst mid-RUN of case 1, then rerun case 2 -> no done from the aborted operation; second result 13.
   With MINV_ITER_LIMIT_EN: p=2^256-189, a=2^255 -> iter_cnt <= 513 and err=0.
